// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI3-subset slave that terminates a memory port on an on-chip SRAM.
// Defining AXI_RESP_PROTOCOL_CHECK_EN compiles in a sticky protocol-violation checker.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif

module axi_sram_responder #(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int MEM_AW       = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  protocol_error
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  localparam logic [3:0] LAT_LAST = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic              rst_done;
  w_state_t          w_state, w_state_nxt;
  logic [3:0]        w_id, w_len, w_cnt;
  logic [MEM_AW-1:0] w_addr, w_beat_addr;
  logic              aw_hs, w_hs, w_last_beat;

  r_state_t          r_state, r_state_nxt;
  logic [3:0]        r_id, r_len, r_cnt, lat_cnt;
  logic [MEM_AW-1:0] r_addr;
  logic              ar_hs, r_hs, r_last_beat, lat_done;
  logic              r_load, r_load_last;
  logic [MEM_AW-1:0] r_load_addr;
  logic [3:0]        r_load_id;

  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, ARADDR, WLAST, WID};

  // Ready outputs stay low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // ---------------- write channel ----------------
  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_addr = w_addr + MEM_AW'(w_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = rst_done && (w_state == W_IDLE);
    WREADY  = (w_state == W_DATA);
    BVALID  = (w_state == W_RESP);
    BID     = w_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id   <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_addr <= '0;
    end else if (aw_hs) begin
      w_id   <= AWID;
      w_len  <= AWLEN;
      w_cnt  <= '0;
      w_addr <= AWADDR[MEM_AW-1:0];
    end else if (w_hs) begin
      w_cnt  <= w_cnt + 4'd1;
    end
  end

  // Array is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_hs) mem[w_beat_addr] <= WDATA;
  end

  // ---------------- read channel ----------------
  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RVALID & RREADY;
  assign r_last_beat = (r_cnt == r_len);
  assign lat_done    = (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (lat_done) r_state_nxt = R_DATA;
      R_DATA:  if (RREADY && r_last_beat) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = rst_done && (r_state == R_IDLE);
    RVALID  = (r_state == R_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      lat_cnt <= '0;
    end else if (ar_hs) begin
      r_id    <= ARID;
      r_len   <= ARLEN;
      r_cnt   <= '0;
      r_addr  <= ARADDR[MEM_AW-1:0];
      lat_cnt <= '0;
    end else if (r_state == R_WAIT) begin
      lat_cnt <= lat_cnt + 4'd1;
    end else if (r_hs) begin
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  // Pick which word (if any) to register into the R output stage this cycle
  always_comb begin
    r_load      = 1'b0;
    r_load_addr = r_addr;
    r_load_last = (r_len == 4'd0);
    r_load_id   = r_id;
    unique case (r_state)
      R_IDLE: begin
        if (ar_hs && (READ_LATENCY == 0)) begin
          r_load      = 1'b1;
          r_load_addr = ARADDR[MEM_AW-1:0];
          r_load_last = (ARLEN == 4'd0);
          r_load_id   = ARID;
        end
      end
      R_WAIT: begin
        if (lat_done) r_load = 1'b1;
      end
      R_DATA: begin
        if (r_hs && !r_last_beat) begin
          r_load      = 1'b1;
          r_load_addr = r_addr + MEM_AW'(r_cnt + 4'd1);
          r_load_last = ((r_cnt + 4'd1) == r_len);
        end
      end
      default: r_load = 1'b0;
    endcase
  end

  // ---- R output stage: held while stalled, reads old data on a same-word write ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RDATA <= '0;
      RID   <= '0;
      RLAST <= 1'b0;
    end else if (r_load) begin
      RDATA <= mem[r_load_addr];
      RID   <= r_load_id;
      RLAST <= r_load_last;
    end
  end

`ifdef AXI_RESP_PROTOCOL_CHECK_EN
  logic aw_pend, ar_pend, err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend <= 1'b0;
      ar_pend <= 1'b0;
    end else begin
      aw_pend <= AWVALID & ~AWREADY;
      ar_pend <= ARVALID & ~ARREADY;
    end
  end

  assign err_set = (w_hs && (WLAST != w_last_beat)) ||
                   (w_hs && (WID != w_id)) ||
                   (aw_pend && !AWVALID) ||
                   (ar_pend && !ARVALID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       protocol_error <= 1'b0;
    else if (err_set) protocol_error <= 1'b1;
  end
`else
  assign protocol_error = 1'b0;
`endif

endmodule
